arp_tx_engine: RTL and testbench

Parametrised ARP frame transmitter for the RGMII Ethernet datapath, sitting in the `tx_mac_aclk` domain upstream of the TX MAC arbiter. It accepts one ARP command at a time (reply or request), builds the full Ethernet/ARP frame from latched command fields and the local MAC/IP parameters, and streams it out as AXI-Stream with byte-granular `tkeep` at a configurable data width. It replaces the fixed 32-bit reply-only sender. It adds request generation, a command handshake, backpressure-safe output and a frame counter.

---
 rtl/arp_tx_engine_if.sv | 51 +++++
 rtl/arp_tx_engine.sv | 205 ++++++++++++++++++++
 tb/tb_arp_tx_engine.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_tx_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arp_tx_engine_if                                                           |
// | Command handshake and AXI-Stream bundle for the ARP frame transmitter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface arp_tx_engine_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int BYTES = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_op;
   logic [47:0]           cmd_mac;
   logic [31:0]           cmd_ip;

   logic [DATA_WIDTH-1:0] tx_axis_arp_tdata;
   logic [BYTES-1:0]      tx_axis_arp_tkeep;
   logic                  tx_axis_arp_tvalid;
   logic                  tx_axis_arp_tlast;
   logic                  tx_axis_arp_tready;

   // The engine side: takes commands, sources the stream.
   modport master (
      input  cmd_valid,
      output cmd_ready,
      input  cmd_op,
      input  cmd_mac,
      input  cmd_ip,
      output tx_axis_arp_tdata,
      output tx_axis_arp_tkeep,
      output tx_axis_arp_tvalid,
      output tx_axis_arp_tlast,
      input  tx_axis_arp_tready
   );

   modport slave (
      output cmd_valid,
      input  cmd_ready,
      output cmd_op,
      output cmd_mac,
      output cmd_ip,
      input  tx_axis_arp_tdata,
      input  tx_axis_arp_tkeep,
      input  tx_axis_arp_tvalid,
      input  tx_axis_arp_tlast,
      output tx_axis_arp_tready
   );
endinterface
`default_nettype wire

// File: rtl/arp_tx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arp_tx_engine                                                              |
// | Builds ARP reply/request frames from a latched command and streams them    |
// | as AXI-Stream. Define ARP_TX_PAD_EN to pad frames to 60 bytes.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arp_tx_engine #(
   parameter logic [47:0] LOCAL_MAC  = 48'h01_02_03_04_05_06,
   parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_01_01,
   parameter int          DATA_WIDTH = 32
) (
   input  logic            tx_mac_aclk,
   input  logic            tx_mac_reset,
   arp_tx_engine_if.master arp,
   output logic            tx_busy,
   output logic [15:0]     tx_frame_cnt
);

   localparam int BYTES   = DATA_WIDTH / 8;
   localparam int ARP_LEN = 42;
`ifdef ARP_TX_PAD_EN
   localparam int FRAME_LEN = 60;
`else
   localparam int FRAME_LEN = ARP_LEN;
`endif
   localparam int BEATS    = (FRAME_LEN + BYTES - 1) / BYTES;
   localparam int BUF_BITS = BEATS * DATA_WIDTH;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
   begin : g_bad_width
      $error("arp_tx_engine: DATA_WIDTH must be 8, 16, 32 or 64");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Whole frame as a flat vector, byte 0 in the MSBs, zero-filled to a beat multiple.
   function automatic logic [BUF_BITS-1:0] frame_image(
      input logic        op,
      input logic [47:0] mac,
      input logic [31:0] ip
   );
      logic [ARP_LEN*8-1:0] arp_bytes;
      logic [BUF_BITS-1:0]  img;
      arp_bytes = {op ? 48'hFFFF_FFFF_FFFF : mac,
                   LOCAL_MAC,
                   16'h0806,
                   16'h0001,
                   16'h0800,
                   16'h0604,
                   op ? 16'h0001 : 16'h0002,
                   LOCAL_MAC,
                   LOCAL_IP,
                   op ? 48'h0 : mac,
                   ip};
      img = '0;
      img[BUF_BITS-1 -: ARP_LEN*8] = arp_bytes;
      return img;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] beat_data(
      input logic [BUF_BITS-1:0] img,
      input logic [BEAT_W-1:0]   idx
   );
      logic [BUF_BITS-1:0] sh;
      sh = img << (int'(idx) * DATA_WIDTH);
      return sh[BUF_BITS-1 -: DATA_WIDTH];
   endfunction

   // Lane j carries byte idx*BYTES + (BYTES-1-j); lanes past the frame end are dropped.
   function automatic logic [BYTES-1:0] beat_keep(input logic [BEAT_W-1:0] idx);
      logic [BYTES-1:0] k;
      for (int j = 0; j < BYTES; j++) begin
         k[j] = (int'(idx) * BYTES + (BYTES - 1 - j)) < FRAME_LEN;
      end
      return k;
   endfunction

   state_t                state;
   state_t                state_next;
   logic [BEAT_W-1:0]     beat;
   logic [BEAT_W-1:0]     beat_next;
   logic [BEAT_W-1:0]     beat_inc;
   logic                  lat_op;
   logic                  lat_op_next;
   logic [47:0]           lat_mac;
   logic [47:0]           lat_mac_next;
   logic [31:0]           lat_ip;
   logic [31:0]           lat_ip_next;
   logic                  ready;
   logic                  ready_next;
   logic [DATA_WIDTH-1:0] out_data;
   logic [DATA_WIDTH-1:0] out_data_next;
   logic [BYTES-1:0]      out_keep;
   logic [BYTES-1:0]      out_keep_next;
   logic                  out_valid;
   logic                  out_valid_next;
   logic                  out_last;
   logic                  out_last_next;
   logic [15:0]           frame_cnt;
   logic [15:0]           frame_cnt_next;
   logic [BUF_BITS-1:0]   cmd_image;
   logic [BUF_BITS-1:0]   held_image;
   logic                  accept;

   assign cmd_image  = frame_image(arp.cmd_op, arp.cmd_mac, arp.cmd_ip);
   assign held_image = frame_image(lat_op, lat_mac, lat_ip);
   assign beat_inc   = beat + 1'b1;
   assign accept     = arp.cmd_valid && ready;

   always_ff @(posedge tx_mac_aclk) begin
      if (tx_mac_reset) begin
         state     <= ST_IDLE;
         beat      <= '0;
         lat_op    <= 1'b0;
         lat_mac   <= '0;
         lat_ip    <= '0;
         ready     <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_next;
         beat      <= beat_next;
         lat_op    <= lat_op_next;
         lat_mac   <= lat_mac_next;
         lat_ip    <= lat_ip_next;
         ready     <= ready_next;
         out_data  <= out_data_next;
         out_keep  <= out_keep_next;
         out_valid <= out_valid_next;
         out_last  <= out_last_next;
         frame_cnt <= frame_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      beat_next      = beat;
      lat_op_next    = lat_op;
      lat_mac_next   = lat_mac;
      lat_ip_next    = lat_ip;
      out_data_next  = out_data;
      out_keep_next  = out_keep;
      out_valid_next = out_valid;
      out_last_next  = out_last;
      frame_cnt_next = frame_cnt;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               // Beat 0 comes straight from the command so it is valid the next cycle.
               lat_op_next    = arp.cmd_op;
               lat_mac_next   = arp.cmd_mac;
               lat_ip_next    = arp.cmd_ip;
               beat_next      = '0;
               out_data_next  = beat_data(cmd_image, '0);
               out_keep_next  = beat_keep('0);
               out_valid_next = 1'b1;
               out_last_next  = 1'b0;
               state_next     = ST_SEND;
            end
         end
         ST_SEND: begin
            if (arp.tx_axis_arp_tready) begin
               if (beat == LAST_BEAT) begin
                  out_data_next  = '0;
                  out_keep_next  = '0;
                  out_valid_next = 1'b0;
                  out_last_next  = 1'b0;
                  frame_cnt_next = frame_cnt + 16'd1;
                  state_next     = ST_IDLE;
               end else begin
                  beat_next     = beat_inc;
                  out_data_next = beat_data(held_image, beat_inc);
                  out_keep_next = beat_keep(beat_inc);
                  out_last_next = (beat_inc == LAST_BEAT);
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      ready_next = (state_next == ST_IDLE);
   end

   assign arp.cmd_ready          = ready;
   assign arp.tx_axis_arp_tdata  = out_data;
   assign arp.tx_axis_arp_tkeep  = out_keep;
   assign arp.tx_axis_arp_tvalid = out_valid;
   assign arp.tx_axis_arp_tlast  = out_last;
   assign tx_busy                = (state == ST_SEND);
   assign tx_frame_cnt           = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arp_tx_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arp_tx_engine                                                           |
// | Randomised bench for arp_tx_engine at 8/16/32/64-bit widths against a     |
// | byte-level frame model. Honours ARP_TX_PAD_EN.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_arp_tx_engine;

   localparam int N_INST = 4;
`ifdef ARP_TX_PAD_EN
   localparam int FRAME_LEN = 60;
`else
   localparam int FRAME_LEN = 42;
`endif
   localparam logic [47:0] LOCAL_MAC = 48'h01_02_03_04_05_06;
   localparam logic [31:0] LOCAL_IP  = 32'hC0_A8_01_01;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s       [N_INST];
   logic        cmd_valid_s [N_INST];
   logic        cmd_op_s    [N_INST];
   logic [47:0] cmd_mac_s   [N_INST];
   logic [31:0] cmd_ip_s    [N_INST];
   logic        tready_s    [N_INST];
   logic        cmd_ready_s [N_INST];
   logic [63:0] tdata_s     [N_INST];
   logic [7:0]  tkeep_s     [N_INST];
   logic        tvalid_s    [N_INST];
   logic        tlast_s     [N_INST];
   logic        busy_s      [N_INST];
   logic [15:0] cnt_s       [N_INST];

   for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
      localparam int W = 8 << gi;
      arp_tx_engine_if #(.DATA_WIDTH(W)) bus ();

      assign bus.cmd_valid          = cmd_valid_s[gi];
      assign bus.cmd_op             = cmd_op_s[gi];
      assign bus.cmd_mac            = cmd_mac_s[gi];
      assign bus.cmd_ip             = cmd_ip_s[gi];
      assign bus.tx_axis_arp_tready = tready_s[gi];
      assign cmd_ready_s[gi]        = bus.cmd_ready;
      assign tdata_s[gi]            = 64'(bus.tx_axis_arp_tdata);
      assign tkeep_s[gi]            = 8'(bus.tx_axis_arp_tkeep);
      assign tvalid_s[gi]           = bus.tx_axis_arp_tvalid;
      assign tlast_s[gi]            = bus.tx_axis_arp_tlast;

      arp_tx_engine #(
         .LOCAL_MAC  (LOCAL_MAC),
         .LOCAL_IP   (LOCAL_IP),
         .DATA_WIDTH (W)
      ) u_dut (
         .tx_mac_aclk  (clk),
         .tx_mac_reset (rst_s[gi]),
         .arp          (bus),
         .tx_busy      (busy_s[gi]),
         .tx_frame_cnt (cnt_s[gi])
      );
   end

   int          checks = 0;
   int          errors = 0;
   int          exp_cnt;
   logic [7:0]  exp_bytes [64];
   logic [63:0] cap_data  [64];
   logic [7:0]  cap_keep  [64];
   logic        nxt_op;
   logic [47:0] nxt_mac;
   logic [31:0] nxt_ip;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference frame: bytes laid out exactly as the ARP/Ethernet field list reads.
   task automatic make_frame(input logic op, input logic [47:0] mac, input logic [31:0] ip);
      logic [47:0] dst, tha, lm;
      logic [31:0] li;
      lm  = LOCAL_MAC;
      li  = LOCAL_IP;
      dst = op ? 48'hFFFF_FFFF_FFFF : mac;
      tha = op ? 48'h0 : mac;
      for (int i = 0; i < 64; i++) exp_bytes[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         exp_bytes[i]      = dst[47-8*i -: 8];
         exp_bytes[6 + i]  = lm[47-8*i -: 8];
         exp_bytes[22 + i] = lm[47-8*i -: 8];
         exp_bytes[32 + i] = tha[47-8*i -: 8];
      end
      exp_bytes[12] = 8'h08; exp_bytes[13] = 8'h06;
      exp_bytes[14] = 8'h00; exp_bytes[15] = 8'h01;
      exp_bytes[16] = 8'h08; exp_bytes[17] = 8'h00;
      exp_bytes[18] = 8'h06; exp_bytes[19] = 8'h04;
      exp_bytes[20] = 8'h00; exp_bytes[21] = op ? 8'h01 : 8'h02;
      for (int i = 0; i < 4; i++) begin
         exp_bytes[28 + i] = li[31-8*i -: 8];
         exp_bytes[38 + i] = ip[31-8*i -: 8];
      end
   endtask

   function automatic int beats_of(input int inst);
      int b;
      b = 1 << inst;
      return (FRAME_LEN + b - 1) / b;
   endfunction

   function automatic logic [63:0] exp_data(input int inst, input int k);
      logic [63:0] d;
      int b, idx;
      b = 1 << inst;
      d = '0;
      for (int j = 0; j < b; j++) begin
         idx = k * b + (b - 1 - j);
         if (idx < FRAME_LEN) d[8*j +: 8] = exp_bytes[idx];
      end
      return d;
   endfunction

   function automatic logic [7:0] exp_keep(input int inst, input int k);
      logic [7:0] m;
      int b;
      b = 1 << inst;
      m = '0;
      for (int j = 0; j < b; j++) m[j] = (k * b + (b - 1 - j)) < FRAME_LEN;
      return m;
   endfunction

   // mode 0: tready=1; mode 1: random tready plus cmd noise; mode 2: tready=1 and next command held valid.
   task automatic run_frame(input int inst, input logic op, input logic [47:0] mac,
                            input logic [31:0] ip, input int mode);
      int n, k, cyc, nb, w;
      logic hs, stalled, pl;
      logic [63:0] pd;
      logic [7:0] pk;
      w  = 8 << inst;
      nb = beats_of(inst);
      make_frame(op, mac, ip);
      n = 0;
      while (cmd_ready_s[inst] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("w%0d cmd_ready before accept", w), 64'(cmd_ready_s[inst]), 64'd1);
      cmd_op_s[inst]    = op;
      cmd_mac_s[inst]   = mac;
      cmd_ip_s[inst]    = ip;
      cmd_valid_s[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (mode == 2) begin
         cmd_op_s[inst]  = nxt_op;
         cmd_mac_s[inst] = nxt_mac;
         cmd_ip_s[inst]  = nxt_ip;
      end else begin
         cmd_valid_s[inst] = 1'b0;
      end
      check($sformatf("w%0d busy after accept", w), 64'(busy_s[inst]), 64'd1);
      k = 0; cyc = 0; stalled = 1'b0; pd = '0; pk = '0; pl = 1'b0;
      while (k < nb && cyc < 2000) begin
         check($sformatf("w%0d beat%0d tvalid", w, k), 64'(tvalid_s[inst]), 64'd1);
         if (tvalid_s[inst] !== 1'b1) break;
         check($sformatf("w%0d cmd_ready in frame", w), 64'(cmd_ready_s[inst]), 64'd0);
         if (stalled) begin
            check($sformatf("w%0d hold data", w), tdata_s[inst], pd);
            check($sformatf("w%0d hold keep", w), 64'(tkeep_s[inst]), 64'(pk));
            check($sformatf("w%0d hold last", w), 64'(tlast_s[inst]), 64'(pl));
         end
         check($sformatf("w%0d beat%0d data", w, k), tdata_s[inst], exp_data(inst, k));
         check($sformatf("w%0d beat%0d keep", w, k), 64'(tkeep_s[inst]), 64'(exp_keep(inst, k)));
         check($sformatf("w%0d beat%0d last", w, k), 64'(tlast_s[inst]), 64'(k == nb - 1));
         if (mode == 1) begin
            tready_s[inst]    = 1'($urandom_range(0, 1));
            cmd_valid_s[inst] = 1'($urandom_range(0, 1));
            cmd_op_s[inst]    = 1'($urandom_range(0, 1));
            cmd_mac_s[inst]   = {16'($urandom), $urandom};
            cmd_ip_s[inst]    = $urandom;
         end else begin
            tready_s[inst] = 1'b1;
         end
         pd      = tdata_s[inst];
         pk      = tkeep_s[inst];
         pl      = tlast_s[inst];
         hs      = tready_s[inst];
         stalled = !tready_s[inst];
         if (hs) begin
            cap_data[k] = tdata_s[inst];
            cap_keep[k] = tkeep_s[inst];
         end
         @(posedge clk);
         if (hs) k++;
         cyc++;
         if (k < nb) @(negedge clk);
      end
      check($sformatf("w%0d beat count", w), 64'(k), 64'(nb));
      if (mode != 1) check($sformatf("w%0d frame cycles", w), 64'(cyc), 64'(nb));
      exp_cnt++;
      @(negedge clk);
      if (mode != 2) cmd_valid_s[inst] = 1'b0;
      tready_s[inst] = 1'b1;
      check($sformatf("w%0d gap tvalid", w), 64'(tvalid_s[inst]), 64'd0);
      check($sformatf("w%0d gap tlast", w), 64'(tlast_s[inst]), 64'd0);
      check($sformatf("w%0d gap busy", w), 64'(busy_s[inst]), 64'd0);
      check($sformatf("w%0d cmd_ready after frame", w), 64'(cmd_ready_s[inst]), 64'd1);
      check($sformatf("w%0d frame_cnt", w), 64'(cnt_s[inst]), 64'(exp_cnt));
   endtask

   task automatic reset_mid_frame(input int inst);
      int n, w;
      w = 8 << inst;
      make_frame(1'b0, 48'h1122_3344_5566, 32'h0A00_0001);
      n = 0;
      while (cmd_ready_s[inst] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      cmd_op_s[inst]    = 1'b0;
      cmd_mac_s[inst]   = 48'h1122_3344_5566;
      cmd_ip_s[inst]    = 32'h0A00_0001;
      cmd_valid_s[inst] = 1'b1;
      tready_s[inst]    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid_s[inst] = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("w%0d beat4 before reset", w), tdata_s[inst], exp_data(inst, 4));
      rst_s[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w%0d rst tvalid", w), 64'(tvalid_s[inst]), 64'd0);
      check($sformatf("w%0d rst tlast", w), 64'(tlast_s[inst]), 64'd0);
      check($sformatf("w%0d rst tdata", w), tdata_s[inst], 64'd0);
      check($sformatf("w%0d rst tkeep", w), 64'(tkeep_s[inst]), 64'd0);
      check($sformatf("w%0d rst busy", w), 64'(busy_s[inst]), 64'd0);
      check($sformatf("w%0d rst cmd_ready", w), 64'(cmd_ready_s[inst]), 64'd0);
      check($sformatf("w%0d rst frame_cnt", w), 64'(cnt_s[inst]), 64'(exp_cnt));
      rst_s[inst] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w%0d cmd_ready after rst", w), 64'(cmd_ready_s[inst]), 64'd1);
      check($sformatf("w%0d tvalid after rst", w), 64'(tvalid_s[inst]), 64'd0);
   endtask

   task automatic suite(input int inst);
      int w;
      logic op;
      logic [47:0] mac;
      logic [31:0] ip;
      w = 8 << inst;
      exp_cnt = 0;
      @(negedge clk);
      check($sformatf("w%0d reset cmd_ready", w), 64'(cmd_ready_s[inst]), 64'd0);
      check($sformatf("w%0d reset tvalid", w), 64'(tvalid_s[inst]), 64'd0);
      check($sformatf("w%0d reset tlast", w), 64'(tlast_s[inst]), 64'd0);
      check($sformatf("w%0d reset tdata", w), tdata_s[inst], 64'd0);
      check($sformatf("w%0d reset tkeep", w), 64'(tkeep_s[inst]), 64'd0);
      check($sformatf("w%0d reset busy", w), 64'(busy_s[inst]), 64'd0);
      check($sformatf("w%0d reset frame_cnt", w), 64'(cnt_s[inst]), 64'd0);
      rst_s[inst] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w%0d cmd_ready after release", w), 64'(cmd_ready_s[inst]), 64'd1);

      reset_mid_frame(inst);

      run_frame(inst, 1'b0, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0102, 0);
      if (inst == 2) begin
         check("w32 reply beat0", cap_data[0], 64'hA0B1_C2D3);
         check("w32 reply beat5", cap_data[5], 64'h0002_0102);
         check("w32 reply beat10", cap_data[10], 64'h0102_0000);
         check("w32 reply beat10 keep", 64'(cap_keep[10]), (FRAME_LEN == 42) ? 64'hC : 64'hF);
      end
      if (inst == 3) begin
         check("w64 reply last keep", 64'(cap_keep[beats_of(3) - 1]),
               (FRAME_LEN == 42) ? 64'hC0 : 64'hF0);
      end

      run_frame(inst, 1'b1, {16'($urandom), $urandom}, 32'hC0A8_0105, 0);
      if (inst == 2) begin
         check("w32 request beat0", cap_data[0], 64'hFFFF_FFFF);
         check("w32 request beat5", cap_data[5], 64'h0001_0102);
         check("w32 request beat8 tha", cap_data[8], 64'h0);
         check("w32 request beat9 tha", 64'(cap_data[9][31:16]), 64'h0);
         check("w32 request beat10", cap_data[10], 64'h0105_0000);
      end

      for (int f = 0; f < 6; f++) begin
         op  = 1'($urandom_range(0, 1));
         mac = {16'($urandom), $urandom};
         ip  = $urandom;
         run_frame(inst, op, mac, ip, 1);
      end

      op      = 1'($urandom_range(0, 1));
      mac     = {16'($urandom), $urandom};
      ip      = $urandom;
      nxt_op  = ~op;
      nxt_mac = {16'($urandom), $urandom};
      nxt_ip  = $urandom;
      run_frame(inst, op, mac, ip, 2);
      run_frame(inst, nxt_op, nxt_mac, nxt_ip, 0);
      cmd_valid_s[inst] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N_INST; i++) begin
         rst_s[i]       = 1'b1;
         cmd_valid_s[i] = 1'b0;
         cmd_op_s[i]    = 1'b0;
         cmd_mac_s[i]   = '0;
         cmd_ip_s[i]    = '0;
         tready_s[i]    = 1'b1;
      end
      nxt_op  = 1'b0;
      nxt_mac = '0;
      nxt_ip  = '0;
      repeat (3) @(posedge clk);
      for (int i = 0; i < N_INST; i++) suite(i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
